l1_veri_onbellek_denetleyici: RTL and testbench



---
 rtl/l1_veri_onbellek_denetleyici_pkg.sv | 30 +++
 rtl/l1_veri_onbellek_denetleyici_dizisi.sv | 67 ++++++
 rtl/l1_veri_onbellek_denetleyici.sv | 158 +++++++++++++++
 tb/tb_l1_veri_onbellek_denetleyici.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/l1_veri_onbellek_denetleyici_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l1_veri_onbellek_denetleyici_pkg
//  Description : Shared state encodings and address-split helpers for the
//                direct-mapped write-through L1 data cache responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package l1_veri_onbellek_denetleyici_pkg;

    // Controller states: idle, read request/wait, write request/wait.
    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        OKU_ISTEK = 3'd1,
        OKU_BEKLE = 3'd2,
        YAZ_ISTEK = 3'd3,
        YAZ_BEKLE = 3'd4
    } durum_e;

    // Index width: one 32-bit word per line, so the index starts at bit 2.
    function automatic int indeks_genisligi(input int satir_sayisi);
        return $clog2(satir_sayisi);
    endfunction

    // Tag width: whatever remains of the word address above the index.
    function automatic int etiket_genisligi(input int satir_sayisi);
        return 30 - $clog2(satir_sayisi);
    endfunction

endpackage : l1_veri_onbellek_denetleyici_pkg
`default_nettype wire

// File: rtl/l1_veri_onbellek_denetleyici_dizisi.sv
`default_nettype none
// ============================================================================
//  Module      : l1_veri_dizisi
//  Description : Valid/tag/data line storage with combinational read, line
//                fill, byte-masked merge and single-cycle invalidate-all.
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_veri_dizisi
    import l1_veri_onbellek_denetleyici_pkg::*;
#(
    parameter int SATIR_SAYISI = 64,
    parameter int IDX          = indeks_genisligi(SATIR_SAYISI),
    parameter int ETIKET_W     = etiket_genisligi(SATIR_SAYISI)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IDX-1:0]      indeks_i,
    input  logic [ETIKET_W-1:0] etiket_i,
    input  logic                doldur_i,
    input  logic [31:0]         doldur_veri_i,
    input  logic                birlestir_i,
    input  logic [3:0]          maske_i,
    input  logic [31:0]         yaz_veri_i,
    input  logic                gecersizle_i,
    output logic                gecerli_o,
    output logic [ETIKET_W-1:0] etiket_o,
    output logic [31:0]         veri_o
);

    logic [SATIR_SAYISI-1:0] gecerli_q;
    logic [ETIKET_W-1:0]     etiket_q [SATIR_SAYISI];
    logic [31:0]             veri_q   [SATIR_SAYISI];
    logic [31:0]             birlesik_w;

    assign gecerli_o = gecerli_q[indeks_i];
    assign etiket_o  = etiket_q[indeks_i];
    assign veri_o    = veri_q[indeks_i];

    // Byte-lane merge of store data into the currently addressed word.
    for (genvar b = 0; b < 4; b++) begin : g_bayt
        assign birlesik_w[8*b +: 8] = maske_i[b] ? yaz_veri_i[8*b +: 8]
                                                 : veri_q[indeks_i][8*b +: 8];
    end

    // Valid bits: the only reset state; fence clears every line at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gecerli_q <= '0;
        end else if (gecersizle_i) begin
            gecerli_q <= '0;
        end else if (doldur_i) begin
            gecerli_q[indeks_i] <= 1'b1;
        end
    end

    // Tag and data storage: written on fill or on a store that hit.
    always_ff @(posedge clk_i) begin
        if (doldur_i) begin
            etiket_q[indeks_i] <= etiket_i;
            veri_q[indeks_i]   <= doldur_veri_i;
        end else if (birlestir_i) begin
            veri_q[indeks_i]   <= birlesik_w;
        end
    end

endmodule : l1_veri_dizisi
`default_nettype wire

// File: rtl/l1_veri_onbellek_denetleyici.sv
`default_nettype none
// ============================================================================
//  Module      : l1_veri_onbellek_denetleyici
//  Description : Direct-mapped, write-through, no-write-allocate L1 data cache
//                responder. Load hits answer in the request cycle; misses and
//                stores stall while the memory handshake completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_veri_onbellek_denetleyici
    import l1_veri_onbellek_denetleyici_pkg::*;
#(
    parameter int SATIR_SAYISI = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bib_oku_gecerli_i,
    input  logic        bib_yaz_gecerli_i,
    input  logic [31:0] bib_adres_i,
    input  logic [3:0]  bib_maske_i,
    input  logic [31:0] bib_yaz_veri_i,
    input  logic        bib_gecersizle_i,
    output logic        bib_stall_o,
    output logic        bib_oku_gecerli_o,
    output logic [31:0] bib_oku_veri_o,
    output logic        bellek_istek_gecerli_o,
    input  logic        bellek_istek_hazir_i,
    output logic        bellek_yaz_o,
    output logic [31:0] bellek_adres_o,
    output logic [3:0]  bellek_maske_o,
    output logic [31:0] bellek_yaz_veri_o,
    input  logic        bellek_yanit_gecerli_i,
    input  logic [31:0] bellek_oku_veri_i
);

    localparam int IDX      = indeks_genisligi(SATIR_SAYISI);
    localparam int ETIKET_W = etiket_genisligi(SATIR_SAYISI);

    durum_e              durum_q, durum_d;
    logic [IDX-1:0]      indeks_w;
    logic [ETIKET_W-1:0] etiket_w;
    logic                satir_gecerli_w;
    logic [ETIKET_W-1:0] satir_etiket_w;
    logic [31:0]         satir_veri_w;
    logic                isabet_w;
    logic                doldur_w;
    logic                birlestir_w;
    logic                gecersizle_w;
    logic [1:0]          unused_bayt_ofseti_w;

    assign indeks_w             = bib_adres_i[IDX+1:2];
    assign etiket_w             = bib_adres_i[31:IDX+2];
    assign unused_bayt_ofseti_w = bib_adres_i[1:0];
    assign isabet_w             = satir_gecerli_w && (satir_etiket_w == etiket_w);

    // Memory request fields track the held requester inputs directly.
    assign bellek_adres_o    = {bib_adres_i[31:2], 2'b00};
    assign bellek_maske_o    = bib_yaz_gecerli_i ? bib_maske_i : 4'b1111;
    assign bellek_yaz_veri_o = bib_yaz_veri_i;

    l1_veri_dizisi #(
        .SATIR_SAYISI (SATIR_SAYISI)
    ) u_dizi (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .indeks_i      (indeks_w),
        .etiket_i      (etiket_w),
        .doldur_i      (doldur_w),
        .doldur_veri_i (bellek_oku_veri_i),
        .birlestir_i   (birlestir_w),
        .maske_i       (bib_maske_i),
        .yaz_veri_i    (bib_yaz_veri_i),
        .gecersizle_i  (gecersizle_w),
        .gecerli_o     (satir_gecerli_w),
        .etiket_o      (satir_etiket_w),
        .veri_o        (satir_veri_w)
    );

    // State register; reset returns to idle from any transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q <= BOSTA;
        end else begin
            durum_q <= durum_d;
        end
    end

    // Next state, handshake outputs and array controls. Outputs are held at
    // zero while reset is asserted so they drop without waiting for a clock.
    always_comb begin
        durum_d                = durum_q;
        bib_stall_o            = 1'b0;
        bib_oku_gecerli_o      = 1'b0;
        bib_oku_veri_o         = 32'h0;
        bellek_istek_gecerli_o = 1'b0;
        bellek_yaz_o           = 1'b0;
        doldur_w               = 1'b0;
        birlestir_w            = 1'b0;
        gecersizle_w           = 1'b0;
        if (rst_ni) begin
            case (durum_q)
                BOSTA: begin
                    if (bib_yaz_gecerli_i) begin
                        bib_stall_o = 1'b1;
                        durum_d     = YAZ_ISTEK;
                    end else if (bib_oku_gecerli_i) begin
                        if (isabet_w) begin
                            bib_oku_gecerli_o = 1'b1;
                            bib_oku_veri_o    = satir_veri_w;
                        end else begin
                            bib_stall_o = 1'b1;
                            durum_d     = OKU_ISTEK;
                        end
                    end else if (bib_gecersizle_i) begin
                        gecersizle_w = 1'b1;
                    end
                end
                OKU_ISTEK: begin
                    bib_stall_o            = 1'b1;
                    bellek_istek_gecerli_o = 1'b1;
                    if (bellek_istek_hazir_i) begin
                        durum_d = OKU_BEKLE;
                    end
                end
                OKU_BEKLE: begin
                    bib_stall_o = 1'b1;
                    if (bellek_yanit_gecerli_i) begin
                        bib_stall_o       = 1'b0;
                        bib_oku_gecerli_o = 1'b1;
                        bib_oku_veri_o    = bellek_oku_veri_i;
                        doldur_w          = 1'b1;
                        durum_d           = BOSTA;
                    end
                end
                YAZ_ISTEK: begin
                    bib_stall_o            = 1'b1;
                    bellek_istek_gecerli_o = 1'b1;
                    bellek_yaz_o           = 1'b1;
                    if (bellek_istek_hazir_i) begin
                        durum_d = YAZ_BEKLE;
                    end
                end
                YAZ_BEKLE: begin
                    bib_stall_o = 1'b1;
                    if (bellek_yanit_gecerli_i) begin
                        bib_stall_o = 1'b0;
                        birlestir_w = isabet_w;
                        durum_d     = BOSTA;
                    end
                end
                default: begin
                    durum_d = BOSTA;
                end
            endcase
        end
    end

endmodule : l1_veri_onbellek_denetleyici
`default_nettype wire

// File: tb/tb_l1_veri_onbellek_denetleyici.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_veri_onbellek_denetleyici
//  Description : Directed self-checking bench for the L1 data cache responder.
//                Inputs change on the falling edge; outputs are checked 1 ns
//                later, well away from the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_veri_onbellek_denetleyici;

    localparam int SATIR_SAYISI = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        oku = 1'b0;
    logic        yaz = 1'b0;
    logic [31:0] adres = 32'h0;
    logic [3:0]  maske = 4'h0;
    logic [31:0] yveri = 32'h0;
    logic        fence = 1'b0;
    logic        stall;
    logic        oku_gecerli;
    logic [31:0] oku_veri;
    logic        istek;
    logic        hazir = 1'b0;
    logic        myaz;
    logic [31:0] madres;
    logic [3:0]  mmaske;
    logic [31:0] mveri;
    logic        yanit = 1'b0;
    logic [31:0] yanit_veri = 32'h0;

    int testler = 0;
    int hatalar = 0;

    always #5 clk = ~clk;

    l1_veri_onbellek_denetleyici #(
        .SATIR_SAYISI (SATIR_SAYISI)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .bib_oku_gecerli_i      (oku),
        .bib_yaz_gecerli_i      (yaz),
        .bib_adres_i            (adres),
        .bib_maske_i            (maske),
        .bib_yaz_veri_i         (yveri),
        .bib_gecersizle_i       (fence),
        .bib_stall_o            (stall),
        .bib_oku_gecerli_o      (oku_gecerli),
        .bib_oku_veri_o         (oku_veri),
        .bellek_istek_gecerli_o (istek),
        .bellek_istek_hazir_i   (hazir),
        .bellek_yaz_o           (myaz),
        .bellek_adres_o         (madres),
        .bellek_maske_o         (mmaske),
        .bellek_yaz_veri_o      (mveri),
        .bellek_yanit_gecerli_i (yanit),
        .bellek_oku_veri_i      (yanit_veri)
    );

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        testler++;
        assert (gozlenen === beklenen)
        else begin
            hatalar++;
            $error("FAIL %s observed=%h expected=%h", etiket, gozlenen, beklenen);
        end
    endtask

    // Advance to the next falling edge where new inputs are applied.
    task automatic adim();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        kontrol("rst_stall", stall, 0);
        kontrol("rst_okug", oku_gecerli, 0);
        kontrol("rst_istek", istek, 0);
        kontrol("rst_yaz", myaz, 0);
        kontrol("rst_okuveri", oku_veri, 0);
        adim(); adim();
        rst_n = 1'b1;
        hazir = 1'b1;

        // ---------------- cold load 0x100, reply 3 cycles later ----------
        adim(); oku = 1; adres = 32'h100; #1;
        kontrol("cold_stall0", stall, 1);
        kontrol("cold_okug0", oku_gecerli, 0);
        kontrol("cold_istek0", istek, 0);
        adim(); #1;
        kontrol("cold_istek1", istek, 1);
        kontrol("cold_yaz1", myaz, 0);
        kontrol("cold_adr1", madres, 32'h100);
        kontrol("cold_mask1", mmaske, 4'hF);
        kontrol("cold_stall1", stall, 1);
        adim(); #1;
        kontrol("cold_stall2", stall, 1);
        kontrol("cold_istek2", istek, 0);
        adim(); #1;
        kontrol("cold_stall3", stall, 1);
        adim(); yanit = 1; yanit_veri = 32'hDEADBEEF; #1;
        kontrol("cold_stall_yanit", stall, 0);
        kontrol("cold_okug_yanit", oku_gecerli, 1);
        kontrol("cold_veri_yanit", oku_veri, 32'hDEADBEEF);
        adim(); yanit = 0; yanit_veri = 32'h0; #1;
        kontrol("hit_stall", stall, 0);
        kontrol("hit_okug", oku_gecerli, 1);
        kontrol("hit_veri", oku_veri, 32'hDEADBEEF);
        kontrol("hit_istek", istek, 0);

        // ---------------- store 0xAA mask 0001 to cached 0x100 ----------
        adim(); oku = 0; yaz = 1; maske = 4'b0001; yveri = 32'h000000AA; #1;
        kontrol("st_stall0", stall, 1);
        kontrol("st_istek0", istek, 0);
        adim(); #1;
        kontrol("st_istek1", istek, 1);
        kontrol("st_yaz1", myaz, 1);
        kontrol("st_adr1", madres, 32'h100);
        kontrol("st_mask1", mmaske, 4'b0001);
        kontrol("st_veri1", mveri, 32'h000000AA);
        adim(); #1;
        kontrol("st_stall2", stall, 1);
        adim(); yanit = 1; #1;
        kontrol("st_stall_yanit", stall, 0);
        kontrol("st_okug_yanit", oku_gecerli, 0);
        adim(); yanit = 0; yaz = 0; maske = 4'h0; yveri = 32'h0; oku = 1; #1;
        kontrol("merge_stall", stall, 0);
        kontrol("merge_veri", oku_veri, 32'hDEADBEAA);
        kontrol("merge_istek", istek, 0);

        // ---------------- store to uncached 0x204, no allocate ------------
        adim(); oku = 0; yaz = 1; adres = 32'h204; maske = 4'hF; yveri = 32'h0BADF00D; #1;
        kontrol("wt_stall0", stall, 1);
        adim(); #1;
        kontrol("wt_istek1", istek, 1);
        kontrol("wt_yaz1", myaz, 1);
        kontrol("wt_adr1", madres, 32'h204);
        kontrol("wt_mask1", mmaske, 4'hF);
        adim(); yanit = 1; #1;
        kontrol("wt_stall_yanit", stall, 0);
        adim(); yanit = 0; yaz = 0; maske = 4'h0; yveri = 32'h0; oku = 1; #1;
        kontrol("wt_load_miss", stall, 1);
        kontrol("wt_load_okug", oku_gecerli, 0);
        adim(); #1;
        kontrol("wt_load_istek", istek, 1);
        adim(); yanit = 1; yanit_veri = 32'h12345678; #1;
        kontrol("wt_load_veri", oku_veri, 32'h12345678);

        // ---------------- conflict: 0x100 + 4*SATIR_SAYISI -----------------
        adim(); yanit = 0; adres = 32'h100 + 4 * SATIR_SAYISI; #1;
        kontrol("cf_miss", stall, 1);
        adim(); #1;
        kontrol("cf_adr", madres, 32'h200);
        adim(); yanit = 1; yanit_veri = 32'hCAFEF00D; #1;
        kontrol("cf_veri", oku_veri, 32'hCAFEF00D);
        adim(); yanit = 0; adres = 32'h100; #1;
        kontrol("cf_evicted", stall, 1);
        adim(); #1;
        kontrol("cf_istek", istek, 1);
        adim(); yanit = 1; yanit_veri = 32'h11111111; #1;
        kontrol("cf_refill", oku_veri, 32'h11111111);
        adim(); yanit = 0; yanit_veri = 32'h0; #1;
        kontrol("cf_hit_stall", stall, 0);
        kontrol("cf_hit_veri", oku_veri, 32'h11111111);
        adim(); adres = 32'h204; #1;
        kontrol("pre_fence_hit", oku_veri, 32'h12345678);
        kontrol("pre_fence_stall", stall, 0);

        // ---------------- fence ----------------
        adim(); oku = 0; fence = 1; #1;
        kontrol("fence_stall", stall, 0);
        kontrol("fence_istek", istek, 0);
        adim(); fence = 0; oku = 1; adres = 32'h100; hazir = 0; #1;
        kontrol("post_fence_miss", stall, 1);
        kontrol("post_fence_okug", oku_gecerli, 0);

        // ---------------- request held while memory not ready -------------
        for (int i = 0; i < 5; i++) begin
            adim(); #1;
            kontrol("hold_istek", istek, 1);
            kontrol("hold_adr", madres, 32'h100);
            kontrol("hold_stall", stall, 1);
        end

        // ---------------- asynchronous reset mid-wait ---------------------
        #2 rst_n = 1'b0;
        #1;
        kontrol("arst_stall", stall, 0);
        kontrol("arst_istek", istek, 0);
        kontrol("arst_okug", oku_gecerli, 0);
        kontrol("arst_adr", madres, 32'h100);
        adim(); adim();
        rst_n = 1'b1; hazir = 1; adres = 32'h204; #1;
        kontrol("post_rst_miss", stall, 1);
        kontrol("post_rst_istek", istek, 0);
        adim(); #1;
        kontrol("post_rst_req", istek, 1);

        $display("[TB] %0d tests run, %0d failed", testler, hatalar);
        $finish;
    end

endmodule : tb_l1_veri_onbellek_denetleyici
`default_nettype wire
